// File: rtl/msb_detect_pkg.sv
// Shared constants and helpers for the pipelined MSB/LSB locator.
package msb_detect_pkg;

  localparam logic MODE_MSB = 1'b0;
  localparam logic MODE_LSB = 1'b1;

  // Elaboration-time ceil(log2); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/msb_chunk_enc.sv
// Combinational N-bit priority encoder: index of the highest (MSB mode) or
// lowest (LSB mode) set bit, plus a nonzero flag.
module msb_chunk_enc
  import msb_detect_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  bits,
  input  logic          mode,
  output logic          nonzero,
  output logic [IW-1:0] idx
);

  // Scan order is chosen so the last match wins: upward for MSB, downward for LSB.
  always_comb begin
    idx     = '0;
    nonzero = |bits;
    if (mode == MODE_MSB) begin
      for (int i = 0; i < N; i++) begin
        if (bits[i]) idx = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bits[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/msb_detect_pipe.sv
// Two-stage valid/ready MSB/LSB locator: S1 encodes each LANE-bit chunk,
// S2 picks the winning chunk and forms {chunk_index, local_index}.
module msb_detect_pipe
  import msb_detect_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int POS_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_num,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] output_pos,
  output logic             out_zero,
  output logic             out_mode
);

  localparam int NCH = WIDTH / LANE;
  localparam int LW  = clog2(LANE);

  logic [NCH-1:0]         lane_nz;
  logic [NCH-1:0][LW-1:0] lane_idx;

  logic                   s1_valid;
  logic [NCH-1:0]         s1_nz;
  logic [NCH-1:0][LW-1:0] s1_idx;
  logic                   s1_mode;

  logic                   s1_advance;
  logic                   s2_advance;
  logic [POS_W-1:0]       s2_pos;
  logic                   s2_zero;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = !s1_valid || s1_advance;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    msb_chunk_enc #(.N(LANE)) u_lane_enc (
      .bits    (input_num[c*LANE +: LANE]),
      .mode    (in_mode),
      .nonzero (lane_nz[c]),
      .idx     (lane_idx[c])
    );
  end

  // Chunk selection reuses the encoder on the per-chunk nonzero vector.
  if (NCH > 1) begin : g_sel
    localparam int CW = clog2(NCH);
    logic          any_nz;
    logic [CW-1:0] sel;

    msb_chunk_enc #(.N(NCH)) u_sel_enc (
      .bits    (s1_nz),
      .mode    (s1_mode),
      .nonzero (any_nz),
      .idx     (sel)
    );

    assign s2_zero = !any_nz;
    assign s2_pos  = any_nz ? {sel, s1_idx[sel]} : '0;
  end else begin : g_single
    assign s2_zero = !s1_nz[0];
    assign s2_pos  = s1_nz[0] ? s1_idx[0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      output_pos <= '0;
      out_zero   <= 1'b0;
      out_mode   <= MODE_MSB;
    end else begin
      if (s1_advance) s1_valid <= in_valid;
      if (s2_advance) out_valid <= s1_valid;
      if (s1_valid && s2_advance) begin
        output_pos <= s2_pos;
        out_zero   <= s2_zero;
        out_mode   <= s1_mode;
      end
    end
  end

  // Stage-1 payload carries no reset; only the valid bit matters.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_nz   <= lane_nz;
      s1_idx  <= lane_idx;
      s1_mode <= in_mode;
    end
  end

endmodule

// File: doc/msb_detect_pipe.md
Name: msb_detect_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit MSB locator.
- Finds either the most- or least-significant set bit of a WIDTH-bit word, selected per transaction.
- Flags all-zero inputs.
- Uses a two-stage valid/ready pipeline, so it sits inline in datapaths (normalisers, arbiters, FP pre-shift) under backpressure.

Parameters:
- WIDTH, 32: input word width; power of two, >= 4.
- LANE, 8: chunk width for stage-1 partial encoding; power of two, divides WIDTH, 2 <= LANE <= WIDTH.
- POS_W, $clog2(WIDTH): width of the position output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- input_num  input  WIDTH  word to search
- in_mode  input  1  0 = find MSB (highest set bit), 1 = find LSB (lowest set bit)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- output_pos  output  POS_W  bit index of the found bit, 0..WIDTH-1
- out_zero  output  1  input word was all zero
- out_mode  output  1  mode the result was computed in

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-transaction):
  - Stage valids clear immediately, in-flight words are discarded, out_valid=0.
  - output_pos=0, out_zero=0, out_mode=0.
  - in_ready=1 from the first clock edge after rst_n deasserts.
- Transfer: a transfer occurs on a rising edge with valid && ready, on both the input and output sides.
- Stage 1 (S1):
  - Input word is split into NCH=WIDTH/LANE chunks.
  - Per chunk, register: a nonzero flag plus a local index (clog2(LANE) bits) of the highest set bit (mode 0) or lowest set bit (mode 1).
  - Mode is registered alongside.
- Stage 2 (S2):
  - Select the chunk by mode: highest nonzero chunk for MSB, lowest nonzero chunk for LSB.
  - output_pos = {chunk_index, local_index}.
  - out_zero = no chunk nonzero; on zero, output_pos=0.
- Latency: exactly 2 cycles from input transfer to out_valid when unstalled.
- Throughput: 1 word/cycle.
- Flow control:
  - S2 holds when out_valid && !out_ready.
  - S1 advances iff S1 is empty or S2 is empty or S2 is transferring.
  - in_ready = !s1_valid || s1_advance. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall:
  - While out_valid && !out_ready, output_pos, out_zero and out_mode are held stable.
  - No word is dropped or duplicated.
  - At most 2 words are held in flight.
- Simultaneous input and output transfer: both occur in the same cycle and the pipeline keeps full throughput.
- Bubbles: when in_valid=0, an empty slot propagates and out_valid drops accordingly.
- Registered data stages are not reset (valids only). The output registers are reset for the defined reset values above.
- Edge cases:
  - Only bit WIDTH-1 set gives pos=WIDTH-1 in both modes.
  - Only bit 0 set gives pos=0 in both modes, with out_zero=0.

Decomposition:
- Package msb_detect_pkg holds:
  - MODE_MSB=1'b0 and MODE_LSB=1'b1 constants.
  - A clog2 helper function, used for the POS_W/local index widths.
- One natural sub-module, msb_chunk_enc:
  - Combinational LANE-bit priority encoder with mode input; outputs nonzero flag and local index.
  - Instantiated NCH times in S1 via generate.
  - The same logic is reused for the chunk select in S2, with the NCH-bit nonzero vector as input.

Test Plan:
- WIDTH=32, mode 0, back-to-back inputs 32'h31003131, 32'h00003131, 32'h00000001, out_ready=1 -> output_pos 29, 13, 0 on consecutive cycles, 2 cycles after each input, out_zero=0.
- Mode 1 on 32'h31003130, 32'h80000000, 32'h00010000 -> output_pos 4, 31, 16.
- 32'h00000000 in both modes -> out_zero=1, output_pos=0, out_mode echoes in_mode.
- Stream 6 words with out_ready held low for 4 cycles mid-stream -> in_ready drops after 2 words are held, outputs stay stable, all 6 results emerge in order with none lost or duplicated.
- Assert rst_n low for 1 cycle asynchronously (between edges) with 2 words in flight -> out_valid=0 immediately, those results never appear, the next input produces a correct result 2 cycles after transfer.
- Parameter sweep with WIDTH=64, LANE=4 and WIDTH=16, LANE=16 -> random words checked against a reference model in both modes.
